// File: rtl/counter_run_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the counter run controller.
package counter_run_ctrl_pkg;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_START     = 3'd1;
   localparam logic [2:0] OP_STOP      = 3'd2;
   localparam logic [2:0] OP_CLEAR     = 3'd3;
   localparam logic [2:0] OP_SET_PRE   = 3'd4;
   localparam logic [2:0] OP_CMP_SHIFT = 3'd5;
   localparam logic [2:0] OP_ARM       = 3'd6;
   localparam logic [2:0] OP_DISARM    = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CLR  = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

endpackage

// File: rtl/counter_run_ctrl_tick_prescaler.sv
// Prescaler: tick asserts once every div+1 run cycles; count holds when not running.
module tick_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRE_W-1:0] pre_div_q, pre_div_d;

   assign tick = (pre_cnt_q == pre_div_q);

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      pre_div_d = pre_div_q;
      // A new divide ratio restarts the phase even mid-run
      if (load) begin
         pre_div_d = div;
         pre_cnt_d = '0;
      end else if (sync_clr) begin
         pre_cnt_d = '0;
      end else if (run) begin
         pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
         pre_div_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pre_div_q <= pre_div_d;
      end
   end

endmodule

// File: rtl/counter_run_ctrl.sv
// Command-driven start/stop/clear/prescale sequencer with compare-stop for the tile counter.
// Optional macro COUNTER_RUN_CTRL_AUTORELOAD_EN: compare hit reloads the counter instead of holding.
module counter_run_ctrl
   import counter_run_ctrl_pkg::*;
#(
   parameter int CNT_W = 24,
   parameter int PRE_W = 8,
   parameter int ARG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [ARG_W-1:0] cmd_arg,
   input  logic [CNT_W-1:0] cnt_q,
   output logic             cnt_inc,
   output logic             cnt_clr,
   output logic             match,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   logic             resume_q, resume_d;
   logic [CNT_W-1:0] cmp_q, cmp_d;
   logic             armed_q, armed_d;
   logic             match_q, match_d;
   logic             accept, hit, tick;

   assign cmd_ready = (state_q != ST_CLR);
   assign accept    = cmd_valid && cmd_ready;
   assign hit       = armed_q && (cnt_q == cmp_q) && (state_q == ST_RUN);
   assign cnt_inc   = (state_q == ST_RUN) && tick && !hit;
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
   assign cnt_clr   = (state_q == ST_CLR) || hit;
`else
   assign cnt_clr   = (state_q == ST_CLR);
`endif
   assign match     = match_q;
   assign state     = state_q;

   tick_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (state_q == ST_RUN),
      .sync_clr (state_q == ST_CLR),
      .load     (accept && (cmd_op == OP_SET_PRE)),
      .div      (cmd_arg[PRE_W-1:0]),
      .tick     (tick)
   );

   always_comb begin
      state_d  = state_q;
      resume_d = resume_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && cmd_op == OP_START) begin
               state_d = ST_RUN;
            end else if (accept && cmd_op == OP_CLEAR) begin
               state_d  = ST_CLR;
               resume_d = 1'b0;
            end
         end
         ST_RUN: begin
            // Explicit STOP/CLEAR beat the compare hit; other ops let the hit win
            if (accept && cmd_op == OP_STOP) begin
               state_d = ST_IDLE;
            end else if (accept && cmd_op == OP_CLEAR) begin
               state_d  = ST_CLR;
               resume_d = 1'b1;
            end else if (hit) begin
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
               state_d = ST_RUN;
`else
               state_d = ST_HOLD;
`endif
            end
         end
         ST_CLR: state_d = resume_q ? ST_RUN : ST_IDLE;
         ST_HOLD: begin
            if (accept && cmd_op == OP_START) begin
               state_d  = ST_CLR;
               resume_d = 1'b1;
            end else if (accept && cmd_op == OP_STOP) begin
               state_d = ST_IDLE;
            end else if (accept && cmd_op == OP_CLEAR) begin
               state_d  = ST_CLR;
               resume_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmp_d   = cmp_q;
      armed_d = armed_q;
      match_d = hit;
      if (accept && cmd_op == OP_CMP_SHIFT) cmp_d = {cmp_q[CNT_W-ARG_W-1:0], cmd_arg};
      if (accept && cmd_op == OP_ARM)       armed_d = 1'b1;
      if (accept && cmd_op == OP_DISARM)    armed_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         resume_q <= 1'b0;
         cmp_q    <= '0;
         armed_q  <= 1'b0;
         match_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         cmp_q    <= cmp_d;
         armed_q  <= armed_d;
         match_q  <= match_d;
      end
   end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: directed scenarios plus random commands against a cycle model.
module tb_counter_run_ctrl;

   localparam int CNT_W = 24;
   localparam int PRE_W = 8;
   localparam int ARG_W = 8;
`ifdef COUNTER_RUN_CTRL_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'd0;
   logic [ARG_W-1:0] cmd_arg = '0;
   logic [CNT_W-1:0] cnt = '0;
   logic             cnt_inc, cnt_clr, match;
   logic [1:0]       state;

   int checks = 0;
   int failures = 0;

   // reference model: states 0 IDLE, 1 RUN, 2 CLR, 3 HOLD
   int          m_st;
   bit          m_resume, m_armed, m_match;
   int          m_pre_div, m_pre_cnt;
   bit [CNT_W-1:0] m_cmp;
   int          n_match;

   counter_run_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W), .ARG_W(ARG_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_q(cnt), .cnt_inc(cnt_inc),
      .cnt_clr(cnt_clr), .match(match), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit();
      return m_armed && (cnt == m_cmp) && (m_st == 1);
   endfunction

   task automatic model_reset();
      m_st = 0; m_resume = 0; m_armed = 0; m_match = 0;
      m_pre_div = 0; m_pre_cnt = 0; m_cmp = '0; cnt = '0;
   endtask

   // One clock: drive, check combinational/registered outputs, then advance model and counter
   task automatic cyc(input bit v, input bit [2:0] op, input bit [7:0] arg);
      bit e_ready, e_hit, e_tick, e_inc, e_clr, acc;
      int n_st;
      @(negedge clk);
      cmd_valid = v; cmd_op = op; cmd_arg = arg;
      #1;
      e_ready = (m_st != 2);
      e_hit   = m_hit();
      e_tick  = (m_pre_cnt == m_pre_div);
      e_inc   = (m_st == 1) && e_tick && !e_hit;
      e_clr   = (m_st == 2) || (AR && e_hit);
      chk("state", 32'(state), 32'(m_st));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("cnt_inc", 32'(cnt_inc), 32'(e_inc));
      chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
      chk("match", 32'(match), 32'(m_match));
      if (m_match) n_match++;
      acc  = v && e_ready;
      n_st = m_st;
      case (m_st)
         0: if (acc && op == 3'd1) n_st = 1;
            else if (acc && op == 3'd3) begin n_st = 2; m_resume = 0; end
         1: if (acc && op == 3'd2) n_st = 0;
            else if (acc && op == 3'd3) begin n_st = 2; m_resume = 1; end
            else if (e_hit) n_st = AR ? 1 : 3;
         2: n_st = m_resume ? 1 : 0;
         default: if (acc && op == 3'd1) begin n_st = 2; m_resume = 1; end
            else if (acc && op == 3'd2) n_st = 0;
            else if (acc && op == 3'd3) begin n_st = 2; m_resume = 0; end
      endcase
      @(posedge clk);
      #1;
      if (acc && op == 3'd4) begin m_pre_div = arg; m_pre_cnt = 0; end
      else if (m_st == 2) m_pre_cnt = 0;
      else if (m_st == 1) m_pre_cnt = e_tick ? 0 : m_pre_cnt + 1;
      if (acc && op == 3'd5) m_cmp = {m_cmp[CNT_W-ARG_W-1:0], arg};
      if (acc && op == 3'd6) m_armed = 1;
      if (acc && op == 3'd7) m_armed = 0;
      m_match = e_hit;
      m_st = n_st;
      if (e_clr) cnt = '0;
      else if (e_inc) cnt = cnt + 1'b1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 8'd0);
   endtask

   initial begin
      int c0;
      bit found;
      n_match = 0;
      model_reset();
      // reset state
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_inc", 32'(cnt_inc), 32'd0);
      chk("rst_clr", 32'(cnt_clr), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_match", 32'(match), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // free run at pre_div=0, then stop
      cyc(1, 3'd1, 0);
      c0 = int'(cnt);
      nops(6);
      chk("run_adv6", 32'(int'(cnt) - c0), 32'd6);
      cyc(1, 3'd2, 0);
      nops(2);
      chk("stop_idle", 32'(state), 32'd0);

      // divide by 4: 25 increments per 100 run cycles
      cyc(1, 3'd4, 8'd3);
      cyc(1, 3'd1, 0);
      c0 = int'(cnt);
      nops(100);
      chk("pre4_adv", 32'(int'(cnt) - c0), 32'd25);
      cyc(1, 3'd2, 0);

      // compare-stop at 10
      cyc(1, 3'd4, 8'd0);
      cyc(1, 3'd5, 8'h00); cyc(1, 3'd5, 8'h00); cyc(1, 3'd5, 8'h0A);
      cyc(1, 3'd6, 0);
      cyc(1, 3'd3, 0);
      nops(1);
      cyc(1, 3'd1, 0);
      n_match = 0;
      nops(20);
      if (!AR) begin
         chk("cmp_stop_cnt", 32'(cnt), 32'd10);
         chk("cmp_hold", 32'(state), 32'd3);
         chk("match_once", 32'(n_match), 32'd1);
         cyc(1, 3'd1, 0);
         chk("hold_start_clr", 32'(state), 32'd2);
         chk("clr_not_ready", 32'(cmd_ready), 32'd0);
         nops(2);
         chk("resume_run", 32'(state), 32'd1);
      end

      // CLEAR collides with hit: state goes CLR and match still pulses
      cyc(1, 3'd2, 0);
      cyc(1, 3'd3, 0); nops(1);
      cyc(1, 3'd1, 0);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_hit()) begin
            cyc(1, 3'd3, 0);
            found = 1;
         end else nops(1);
      end
      checks++;
      assert (found) else begin
         failures++;
         $error("FAIL hit_timeout observed=0 expected=1");
      end
      chk("clr_hit_state", 32'(state), 32'd2);
      chk("clr_hit_match", 32'(match), 32'd1);
      nops(1);
      chk("clr_hit_cnt", 32'(cnt), 32'd0);

      // randomized commands; small cmp bytes keep hits reachable
      for (int i = 0; i < 400; i++) begin
         bit [2:0] op;
         bit [7:0] arg;
         op  = 3'($urandom_range(0, 7));
         arg = (op == 3'd5) ? 8'($urandom_range(0, 2)) :
               (op == 3'd4) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         if (op == 3'd3 && $urandom_range(0, 3) != 0) op = 3'd0;
         cyc(($urandom_range(0, 9) < 7), op, arg);
      end

      // reset mid-run with pre_cnt==2
      cyc(1, 3'd4, 8'd3);
      cyc(1, 3'd7, 0);
      cyc(1, 3'd1, 0);
      nops(2);
      chk("pre_cnt2_run", 32'(m_st == 1 && m_pre_cnt == 2), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_inc", 32'(cnt_inc), 32'd0);
      chk("midrst_clr", 32'(cnt_clr), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      // cmp and armed cleared: counter at 0 with cmp 0 must not hit if unarmed
      cyc(1, 3'd1, 0);
      nops(4);
      chk("post_rst_run", 32'(state), 32'd1);
      chk("post_rst_cnt", 32'(cnt), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
